// File: rtl/adder_pipe.sv
// adder_pipe: pipelined M = N*K bit adder (sum = a + b + cin), one N-bit chunk
// per stage, with the chunk carry registered between stages.
//
// Optional feature: define ADDER_PIPE_SUB_EN to add the 'sub' input. With
// sub=1 the block computes a - b (b inverted chunk by chunk, carry-in forced
// to 1, cin ignored); cout=1 then means no borrow.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operand set on a/b/cin (and sub) is valid
//   in_ready   block accepts operands this cycle (combinational)
//   a, b       M-bit unsigned operands
//   cin        carry-in to chunk 0
//   sub        (ADDER_PIPE_SUB_EN only) subtract b instead of adding it
//   out_valid  sum/cout valid (registered)
//   out_ready  downstream accepts the result this cycle
//   sum        registered result, M bits
//   cout       registered carry-out of the last chunk
module adder_pipe #(
  parameter int unsigned N = 4,
  parameter int unsigned K = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           cin,
`ifdef ADDER_PIPE_SUB_EN
  input  logic           sub,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] sum,
  output logic           cout
);

  localparam int unsigned M = N * K;

  // Per-stage registers. Operands and result bits keep their absolute bit
  // positions: stage s consumes bits [s*N +: N] of a/b and fills the same
  // slice of r. Untouched operand chunks ride along with their transaction.
  logic [M-1:0] a_q   [K];
  logic [M-1:0] b_q   [K];
  logic [M-1:0] r_q   [K];
  logic         c_q   [K];
  logic         v_q   [K];
  logic         sub_q [K];

  // Next-state values for every stage
  logic [M-1:0] a_d   [K];
  logic [M-1:0] b_d   [K];
  logic [M-1:0] r_d   [K];
  logic         c_d   [K];
  logic         v_d   [K];
  logic         sub_d [K];

  // Per-stage working values inside the comb loop
  logic [M-1:0] a_src;
  logic [M-1:0] b_src;
  logic [M-1:0] r_src;
  logic         c_src;
  logic         v_src;
  logic         sub_src;
  logic [N-1:0] b_chunk;
  logic [N:0]   chunk_sum;

  // Stage-0 carry-in and subtract select
  logic         sub_in;
  logic         cin_eff;

  logic         advance;

`ifdef ADDER_PIPE_SUB_EN
  assign sub_in  = sub;
  assign cin_eff = sub | cin;
`else
  assign sub_in  = 1'b0;
  assign cin_eff = cin;
`endif

  // Single global stall: the whole pipe moves only when the output slot frees
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Chunk adders: stage s adds chunk s with the carry held by stage s-1
  always_comb begin
    a_src     = '0;
    b_src     = '0;
    r_src     = '0;
    c_src     = 1'b0;
    v_src     = 1'b0;
    sub_src   = 1'b0;
    b_chunk   = '0;
    chunk_sum = '0;
    for (int s = 0; s < K; s++) begin
      a_d[s]   = '0;
      b_d[s]   = '0;
      r_d[s]   = '0;
      c_d[s]   = 1'b0;
      v_d[s]   = 1'b0;
      sub_d[s] = 1'b0;
    end

    for (int s = 0; s < K; s++) begin
      if (s == 0) begin
        a_src   = a;
        b_src   = b;
        r_src   = '0;
        c_src   = cin_eff;
        v_src   = in_valid;
        sub_src = sub_in;
      end else begin
        a_src   = a_q[s-1];
        b_src   = b_q[s-1];
        r_src   = r_q[s-1];
        c_src   = c_q[s-1];
        v_src   = v_q[s-1];
        sub_src = sub_q[s-1];
      end

      // Subtraction inverts b chunk by chunk as the transaction moves along
      b_chunk   = b_src[s*N +: N] ^ {N{sub_src}};
      chunk_sum = {1'b0, a_src[s*N +: N]} + {1'b0, b_chunk} + (N+1)'(c_src);

      r_src[s*N +: N] = chunk_sum[N-1:0];

      a_d[s]   = a_src;
      b_d[s]   = b_src;
      r_d[s]   = r_src;
      c_d[s]   = chunk_sum[N];
      v_d[s]   = v_src;
      sub_d[s] = sub_src;
    end
  end

  // Stage registers; everything holds while the output is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < K; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        r_q[s]   <= '0;
        c_q[s]   <= 1'b0;
        v_q[s]   <= 1'b0;
        sub_q[s] <= 1'b0;
      end
    end else if (advance) begin
      for (int s = 0; s < K; s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        r_q[s]   <= r_d[s];
        c_q[s]   <= c_d[s];
        v_q[s]   <= v_d[s];
        sub_q[s] <= sub_d[s];
      end
    end
  end

  // Last stage flops drive the outputs directly
  assign sum       = r_q[K-1];
  assign cout      = c_q[K-1];
  assign out_valid = v_q[K-1];

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and randomised checks of adder_pipe for the
// configurations (N,K) = (4,2), (3,3) and (8,1). All three instances see the
// same operand stream; each has its own expected-result queue filled on an
// input transfer and drained on an output transfer.
module tb_adder_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       a_hi = 1'b0;
  logic       b_hi = 1'b0;
  logic [8:0] a1;
  logic [8:0] b1;

  logic       in_ready0, out_valid0, cout0;
  logic [7:0] sum0;
  logic       in_ready1, out_valid1, cout1;
  logic [8:0] sum1;
  logic       in_ready2, out_valid2, cout2;
  logic [7:0] sum2;

  int checks = 0;
  int errors = 0;

  logic [8:0] q0[$];
  logic [9:0] q1[$];
  logic [8:0] q2[$];

  logic [7:0] sa[3];
  logic [7:0] sb[3];
  logic       sc[3];
  logic [7:0] es[3];
  logic       ec[3];
  logic [7:0] cor[8];

  assign a1 = {a_hi, a};
  assign b1 = {b_hi, b};

  always #5 clk = ~clk;

  adder_pipe #(.N(4), .K(2)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .cin(cin),
`ifdef ADDER_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0), .cout(cout0)
  );

  adder_pipe #(.N(3), .K(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin),
`ifdef ADDER_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1), .cout(cout1)
  );

  adder_pipe #(.N(8), .K(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .cin(cin),
`ifdef ADDER_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .cout(cout2)
  );

  // Reference {cout,sum} for a w-bit add (or subtract when s=1)
  function automatic logic [9:0] model(input logic [8:0] x, input logic [8:0] y,
                                       input logic c, input logic s, input int w);
    logic [9:0] mask;
    logic [9:0] yy;
    mask = (w == 9) ? 10'h1FF : 10'h0FF;
    yy   = s ? ((~{1'b0, y}) & mask) : ({1'b0, y} & mask);
    return ({1'b0, x} & mask) + yy + 10'(s ? 1'b1 : c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: sampled at the falling edge, where the handshake is stable
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid0 && out_ready) begin
        checks++;
        assert (q0.size() > 0) else begin
          errors++;
          $error("FAIL dut0_spurious observed=%h expected=none", {cout0, sum0});
        end
        if (q0.size() > 0) chk("dut0_result", 32'({cout0, sum0}), 32'(q0.pop_front()));
      end
      if (in_valid && in_ready0) q0.push_back(9'(model({1'b0, a}, {1'b0, b}, cin, sub, 8)));
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid1 && out_ready) begin
        checks++;
        assert (q1.size() > 0) else begin
          errors++;
          $error("FAIL dut1_spurious observed=%h expected=none", {cout1, sum1});
        end
        if (q1.size() > 0) chk("dut1_result", 32'({cout1, sum1}), 32'(q1.pop_front()));
      end
      if (in_valid && in_ready1) q1.push_back(model(a1, b1, cin, sub, 9));
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid2 && out_ready) begin
        checks++;
        assert (q2.size() > 0) else begin
          errors++;
          $error("FAIL dut2_spurious observed=%h expected=none", {cout2, sum2});
        end
        if (q2.size() > 0) chk("dut2_result", 32'({cout2, sum2}), 32'(q2.pop_front()));
      end
      if (in_valid && in_ready2) q2.push_back(9'(model({1'b0, a}, {1'b0, b}, cin, sub, 8)));
    end
  end

  // Present one operand set and hold it until dut0 takes it
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic s, input bit throttle);
    bit acc;
    acc      = 1'b0;
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
    a_hi     = 1'($urandom);
    b_hi     = 1'($urandom);
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      out_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      acc = in_ready0;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout observed=%0d expected=1", acc);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      step();
    end
    chk("drain_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sa  = '{8'h12, 8'h0F, 8'h80};
    sb  = '{8'h34, 8'h01, 8'h80};
    sc  = '{1'b0, 1'b1, 1'b0};
    es  = '{8'h46, 8'h11, 8'h00};
    ec  = '{1'b0, 1'b0, 1'b1};
    cor = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h7F, 8'h80, 8'hFE, 8'hFF};

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_sum", 32'(sum0), 32'd0);
    chk("rst_cout", 32'(cout0), 32'd0);
    chk("rst_sum_k3", 32'(sum1), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready0), 32'd1);
    step();

    // Single transaction: 0xFF + 0x01 wraps, two-edge latency
    in_valid = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid0), 32'd0);
    step();
    chk("lat_valid", 32'(out_valid0), 32'd1);
    chk("wrap_sum", 32'(sum0), 32'h00);
    chk("wrap_cout", 32'(cout0), 32'd1);
    step();
    chk("bubble_after", 32'(out_valid0), 32'd0);

    // Back-to-back stream, results on consecutive cycles
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        in_valid = 1'b1; a = sa[i]; b = sb[i]; cin = sc[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 3) begin
        chk("stream_valid", 32'(out_valid0), 32'd1);
        chk("stream_sum", 32'(sum0), 32'(es[i-1]));
        chk("stream_cout", 32'(cout0), 32'(ec[i-1]));
      end
      if (i == 4) chk("stream_end", 32'(out_valid0), 32'd0);
    end

    // Output stall: hold for 5 cycles, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h30; b = 8'h05; cin = 1'b0;
    step();
    a = 8'hF0; b = 8'h20; cin = 1'b1;
    step();
    a = 8'h77; b = 8'h77; cin = 1'b0;
    chk("stall_in_ready", 32'(in_ready0), 32'd0);
    chk("stall_valid", 32'(out_valid0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(out_valid0), 32'd1);
      chk("hold_sum", 32'(sum0), 32'h35);
      chk("hold_cout", 32'(cout0), 32'd0);
      chk("hold_in_ready", 32'(in_ready0), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_valid", 32'(out_valid0), 32'd1);
    chk("release_sum", 32'(sum0), 32'h11);
    chk("release_cout", 32'(cout0), 32'd1);
    step();
    chk("release_end", 32'(out_valid0), 32'd0);
    drain();

    // Reset while a transaction is in flight
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    #1;
    chk("midrst_valid", 32'(out_valid0), 32'd0);
    chk("midrst_sum", 32'(sum0), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_quiet", 32'(out_valid0), 32'd0);
    end

`ifdef ADDER_PIPE_SUB_EN
    // Subtraction: cout=1 means no borrow
    in_valid = 1'b1; a = 8'h10; b = 8'h01; cin = 1'b0; sub = 1'b1; out_ready = 1'b1;
    step();
    a = 8'h01; b = 8'h02; cin = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sub_sum0", 32'(sum0), 32'h0F);
    chk("sub_cout0", 32'(cout0), 32'd1);
    step();
    chk("sub_sum1", 32'(sum0), 32'hFF);
    chk("sub_cout1", 32'(cout0), 32'd0);
    sub = 1'b0;
    drain();
`endif

    // Boundary operand pairs with downstream throttling
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int c = 0; c < 2; c++)
          send(cor[i], cor[j], 1'(c), 1'b0, 1'b1);
    drain();

    // Random operands, random bubbles, random throttling
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        step();
      end
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
